core_iencode: RTL and testbench
===============================

CORE_IENCODE -- requirements
Module: core_iencode

Interface
REQ-001 SHALL: CLK  input  1  single clock; every register updates on its rising edge.
REQ-002 SHALL: RST  input  1  reset, asynchronous and active-high.
REQ-003 SHALL: IN_VALID  input  1  the request fields below are valid.
REQ-004 SHALL: IN_READY  output  1  the block can accept a request this cycle.
REQ-005 SHALL: OPCODE  input  7  RV32I major opcode.
REQ-006 SHALL: FUNCT3, FUNCT7  input  3, 7  function fields.
REQ-007 SHALL: RD, RS1, RS2  input  5 each  register indices.
REQ-008 SHALL: IMM  input  32  logical immediate, byte-offset form, as the decoder produces it.
REQ-009 SHALL: OUT_VALID  output  1  INSTRUCTION and ERR are valid.
REQ-010 SHALL: OUT_READY  input  1  the consumer takes the output this cycle.
REQ-011 SHALL: INSTRUCTION  output  32  encoded instruction word.
REQ-012 SHALL: ERR  output  1  the request was not encodable; INSTRUCTION is then 32'h00000013 (NOP).
REQ-013 SHALL: COUNT  output  16  number of completed output handshakes, wrapping.

Function
REQ-014 SHALL: input handshake is IN_VALID&&IN_READY at a rising edge; output handshake is OUT_VALID&&OUT_READY at a rising edge.
REQ-015 SHALL: latency is one cycle; a request accepted at edge N into an empty block gives OUT_VALID=1 after edge N.
REQ-016 SHALL: the block has three states: EMPTY, ONE (output register full), TWO (output register plus skid register full); IN_READY=1 exactly when the state is not TWO.
REQ-017 SHALL: transitions:
  - EMPTY + input -> ONE.
  - ONE + input, no output -> TWO (request goes to skid).
  - ONE + output, no input -> EMPTY.
  - ONE + input + output -> ONE, new word loaded.
  - TWO + output -> ONE, skid moves to the output register.
  - All other cases hold the current state.
REQ-018 SHALL: while OUT_VALID=1 and OUT_READY=0, INSTRUCTION and ERR stay stable; words leave in acceptance order with no loss or duplication.
REQ-019 SHALL: R-type (0110011): {FUNCT7,RS2,RS1,FUNCT3,RD,OPCODE}; never ERR.
REQ-020 SHALL: I-type (0010011, 0000011, 1100111): {IMM[11:0],RS1,FUNCT3,RD,OPCODE}; ERR if IMM[31:11] is not all-equal.
REQ-021 SHALL: shifts (0010011 with FUNCT3=001 or 101): {FUNCT7,IMM[4:0],RS1,FUNCT3,RD,OPCODE}; ERR if IMM[31:5]!=0.
REQ-022 SHALL: S-type (0100011): {IMM[11:5],RS2,RS1,FUNCT3,IMM[4:0],OPCODE}; ERR if IMM[31:11] is not all-equal.
REQ-023 SHALL: B-type (1100011): {IMM[12],IMM[10:5],RS2,RS1,FUNCT3,IMM[4:1],IMM[11],OPCODE}; ERR if IMM[0]=1 or IMM[31:12] is not all-equal.
REQ-024 SHALL: U-type (0110111, 0010111): {IMM[31:12],RD,OPCODE}; ERR if IMM[11:0]!=0.
REQ-025 SHALL: J-type (1101111): {IMM[20],IMM[10:1],IMM[11],IMM[19:12],RD,OPCODE}; ERR if IMM[0]=1 or IMM[31:20] is not all-equal.
REQ-026 SHALL: any other OPCODE sets ERR=1.
REQ-027 SHALL: fields unused by the selected format are ignored.
REQ-028 SHALL: COUNT increments by 1 on every output handshake, including ERR words, and wraps 16'hFFFF -> 16'h0000.

Reset
REQ-029 SHALL: RST asserted, at any time and without a clock, forces:
  - state EMPTY, OUT_VALID=0, IN_READY=1;
  - INSTRUCTION=32'h00000013, ERR=0, COUNT=0;
  - skid register cleared.
REQ-030 SHALL: reset mid-operation discards all buffered words; the first edge after RST deasserts may accept a request.

Verification
REQ-031 SHALL: OPCODE=0010011, RD=1, RS1=0, FUNCT3=0, IMM=5, OUT_READY=1 -> next cycle INSTRUCTION=32'h00500093, ERR=0, COUNT=1.
REQ-032 SHALL: OPCODE=1100011, RS1=1, RS2=2, FUNCT3=0, IMM=32'hFFFFFFFC -> INSTRUCTION=32'hFE208EE3; IMM=3 -> INSTRUCTION=32'h00000013, ERR=1.
REQ-033 SHALL: OPCODE=0110111, RD=5, IMM=32'h12345000 -> INSTRUCTION=32'h123452B7; IMM=32'h12345001 -> ERR=1.
REQ-034 SHALL: OUT_READY=0 with three back-to-back requests -> two are accepted and IN_READY=0 on the third; with OUT_READY=1 the words emerge in order and the third is then accepted.
REQ-035 SHALL: RST pulse while in state TWO -> immediately OUT_VALID=0, IN_READY=1, COUNT=0, and no buffered word ever appears afterwards.
REQ-036 SHALL: 65536 output handshakes from reset -> COUNT=0; one more handshake -> COUNT=1.

Source files
------------

// File: rtl/core_iencode.sv
// RV32I instruction encoder: one request field set in, one 32-bit word out.
// The output register and the skid register let a full-rate stream pass through without a bubble.
module core_iencode (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instruction,
    output logic        err,
    output logic [15:0] count
);
    // state | meaning
    // EMPTY | no word held
    // ONE   | output register full
    // TWO   | output register and skid register full
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    state_t      state, state_next;
    logic [31:0] out_word, skid_word, raw_word, enc_word;
    logic        out_err, skid_err, enc_err;
    logic        in_fire, out_fire;
    logic        load_out, load_skid, out_from_skid;
    logic        sext11, sext12, sext20;

    // An immediate fits in N+1 signed bits when every bit from N upwards is equal.
    assign sext11 = (&imm[31:11]) | ~(|imm[31:11]);
    assign sext12 = (&imm[31:12]) | ~(|imm[31:12]);
    assign sext20 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        raw_word = NOP;
        enc_err  = 1'b0;
        case (opcode)
            OP_R: raw_word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    enc_err  = |imm[31:5];
                    raw_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    enc_err  = ~sext11;
                    raw_word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            OP_LOAD, OP_JALR: begin
                enc_err  = ~sext11;
                raw_word = {imm[11:0], rs1, funct3, rd, opcode};
            end
            OP_STORE: begin
                enc_err  = ~sext11;
                raw_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            end
            OP_BRANCH: begin
                enc_err  = imm[0] | ~sext12;
                raw_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            end
            OP_LUI, OP_AUIPC: begin
                enc_err  = |imm[11:0];
                raw_word = {imm[31:12], rd, opcode};
            end
            OP_JAL: begin
                enc_err  = imm[0] | ~sext20;
                raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            end
            default: enc_err = 1'b1;
        endcase
        enc_word = enc_err ? NOP : raw_word;
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    load_out   = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_next    = ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            out_word  <= NOP;
            out_err   <= 1'b0;
            skid_word <= 32'd0;
            skid_err  <= 1'b0;
            count     <= 16'd0;
        end else begin
            state <= state_next;
            if (load_out) begin
                out_word <= out_from_skid ? skid_word : enc_word;
                out_err  <= out_from_skid ? skid_err  : enc_err;
            end
            if (load_skid) begin
                skid_word <= enc_word;
                skid_err  <= enc_err;
            end
            if (out_fire) begin
                count <= count + 16'd1;
            end
        end
    end

    assign instruction = out_word;
    assign err         = out_err;
endmodule

// File: tb/tb_core_iencode.sv
// Directed bench for core_iencode: encodings, error cases, skid buffering, reset and count wrap.
module tb_core_iencode;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic        err;
    logic [15:0] count;

    int checks = 0;
    int passed = 0;
    logic [15:0] exp_count = 16'd0;

    core_iencode dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instruction(instruction), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                           input logic [31:0] im);
        opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    // One request into an empty block, check the word, then let it drain.
    task automatic run_vec(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im,
                           input logic [31:0] exp_ins, input logic exp_err);
        set_req(op, f3, f7, d, s1, s2, im);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_ins"}, instruction, exp_ins);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        step();
        exp_count++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_req(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ins", instruction, 32'h0000_0013);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_count", {16'd0, count}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        run_vec("addi5", 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
        check("addi5_count", {16'd0, count}, 32'd1);
        run_vec("beq_m4", 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        run_vec("beq_odd", 7'b1100011, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0000_0013, 1'b1);
        run_vec("lui", 7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        run_vec("lui_low", 7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
        run_vec("sub", 7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
        run_vec("sw8", 7'b0100011, 3'b010, 7'd0, 5'd31, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0);
        run_vec("jal8", 7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
        run_vec("jal_far", 7'b1101111, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
        run_vec("slli3", 7'b0010011, 3'b001, 7'd0, 5'd1, 5'd1, 5'd0, 32'd3, 32'h0030_9093, 1'b0);
        run_vec("srai3", 7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3, 32'h4030_D093, 1'b0);
        run_vec("srai32", 7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd32, 32'h0000_0013, 1'b1);
        run_vec("addi_m1", 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        run_vec("addi_800", 7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
        run_vec("lw_m4", 7'b0000011, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_2283, 1'b0);
        run_vec("bad_op", 7'b1111111, 3'b000, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'h0000_0013, 1'b1);
        check("table_count", {16'd0, count}, {16'd0, exp_count});

        // Back-pressure: A, B, C offered back to back with the consumer stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        check("bp_ready_a", {31'd0, in_ready}, 32'd1);
        set_req(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        check("bp_ready_b", {31'd0, in_ready}, 32'd0);
        check("bp_hold_a", instruction, 32'h0050_0093);
        set_req(7'b0110111, 3'b000, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        step();
        check("bp_ready_c", {31'd0, in_ready}, 32'd0);
        check("bp_stable_a", instruction, 32'h0050_0093);
        out_ready = 1'b1;
        step();
        exp_count++;
        check("bp_out_b", instruction, 32'h4020_81B3);
        check("bp_ready_after", {31'd0, in_ready}, 32'd1);
        step();
        exp_count++;
        in_valid = 1'b0;
        check("bp_out_c", instruction, 32'h1234_52B7);
        step();
        exp_count++;
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_count", {16'd0, count}, {16'd0, exp_count});

        // Reset while both registers are full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        set_req(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd2, 32'd0);
        step();
        in_valid = 1'b0;
        check("two_before_rst", {31'd0, in_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_count", {16'd0, count}, 32'd0);
        check("mid_rst_ins", instruction, 32'h0000_0013);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_word", {31'd0, out_valid}, 32'd0);
        end

        // Continuous stream: first edge loads, every later edge is one handshake.
        in_valid = 1'b1;
        set_req(7'b0010011, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        check("first_accept", {31'd0, out_valid}, 32'd1);
        repeat (65535) @(posedge clk);
        #1;
        check("count_ffff", {16'd0, count}, 32'h0000_FFFF);
        step();
        check("count_wrap", {16'd0, count}, 32'd0);
        in_valid = 1'b0;
        step();
        check("count_one", {16'd0, count}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
